// File: rtl/ct_spsram_2048x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_2048x32_ctrl
// Brief    : Request/response access controller for one 2048x32 single-port
//            SRAM, with credit-protected response FIFO. Optional post-reset
//            array clear is enabled by defining CT_SPSRAM_INIT_CLR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_2048x32_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_bmask,
    output logic                    resp_vld,
    input  logic                    resp_rdy,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W     = $clog2(RESP_DEPTH + 1);

    localparam logic [CNT_W-1:0] C_CREDIT_MAX = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
`ifdef CT_SPSRAM_INIT_CLR_EN
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_RST = 2'd0,
        ST_CLR = 2'd1,
        ST_RUN = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_RST = 2'd0,
        ST_RUN = 2'd2
    } state_e;
`endif

    state_e                  state_q;
    logic                    req_rdy_q;
    logic                    init_done_q;
    logic                    sram_cen_q;
    logic                    sram_gwen_q;
    logic [DATA_WIDTH-1:0]   sram_wen_q;
    logic [ADDR_WIDTH-1:0]   sram_a_q;
    logic [DATA_WIDTH-1:0]   sram_d_q;

    logic [CNT_W-1:0]        credit_q;
    logic [CNT_W-1:0]        credit_d;
    logic                    rd_p1_q;
    logic                    rd_p2_q;
    logic [DATA_WIDTH-1:0]   fifo_q [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    w_accept;
    logic                    w_acc_rd;
    logic                    w_acc_wr;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rdy_next;
    logic [DATA_WIDTH-1:0]   w_wen;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_accept = req_vld && req_rdy_q;
    assign w_acc_rd = w_accept && !req_wr;
    // A write with no byte enabled is swallowed without touching the array.
    assign w_acc_wr = w_accept && req_wr && (|req_bmask);
    assign w_push   = rd_p2_q;
    assign w_pop    = (count_q != '0) && resp_rdy;

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_wen
        assign w_wen[8*k +: 8] = {8{~req_bmask[k]}};
    end

    always_comb begin
        credit_d = credit_q;
        if (w_acc_rd && !w_pop) begin
            credit_d = credit_q + CNT_W'(1);
        end else if (!w_acc_rd && w_pop) begin
            credit_d = credit_q - CNT_W'(1);
        end
    end

    // Ready is computed from next-cycle credit so it is purely registered.
    assign w_rdy_next = (credit_d < C_CREDIT_MAX);

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= ST_RST;
            req_rdy_q   <= 1'b0;
            init_done_q <= 1'b0;
            sram_cen_q  <= 1'b1;
            sram_gwen_q <= 1'b1;
            sram_wen_q  <= '1;
            sram_a_q    <= '0;
            sram_d_q    <= '0;
        end else begin
            sram_cen_q  <= 1'b1;
            sram_gwen_q <= 1'b1;
            sram_wen_q  <= '1;
            case (state_q)
                ST_RST: begin
`ifdef CT_SPSRAM_INIT_CLR_EN
                    state_q     <= ST_CLR;
                    sram_cen_q  <= 1'b0;
                    sram_gwen_q <= 1'b0;
                    sram_wen_q  <= '0;
                    sram_a_q    <= '0;
                    sram_d_q    <= '0;
`else
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                    req_rdy_q   <= w_rdy_next;
`endif
                end
`ifdef CT_SPSRAM_INIT_CLR_EN
                ST_CLR: begin
                    if (sram_a_q == C_ADDR_LAST) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                        req_rdy_q   <= w_rdy_next;
                    end else begin
                        sram_cen_q  <= 1'b0;
                        sram_gwen_q <= 1'b0;
                        sram_wen_q  <= '0;
                        sram_a_q    <= sram_a_q + ADDR_WIDTH'(1);
                        sram_d_q    <= '0;
                    end
                end
`endif
                ST_RUN: begin
                    req_rdy_q <= w_rdy_next;
                    if (w_acc_rd) begin
                        sram_cen_q <= 1'b0;
                        sram_a_q   <= req_addr;
                    end else if (w_acc_wr) begin
                        sram_cen_q  <= 1'b0;
                        sram_gwen_q <= 1'b0;
                        sram_wen_q  <= w_wen;
                        sram_a_q    <= req_addr;
                        sram_d_q    <= req_wdata;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    // Read pipe: stage 1 = SRAM access cycle, stage 2 = sram_q valid / push.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            credit_q <= '0;
            rd_p1_q  <= 1'b0;
            rd_p2_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            credit_q <= credit_d;
            rd_p1_q  <= w_acc_rd;
            rd_p2_q  <= rd_p1_q;
            if (w_push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign req_rdy    = req_rdy_q;
    assign init_done  = init_done_q;
    assign resp_vld   = (count_q != '0);
    assign resp_rdata = fifo_q[rd_ptr_q];
    assign sram_a     = sram_a_q;
    assign sram_cen   = sram_cen_q;
    assign sram_gwen  = sram_gwen_q;
    assign sram_wen   = sram_wen_q;
    assign sram_d     = sram_d_q;

endmodule
`default_nettype wire
